// File: rtl/gpu_pkg.sv
// gpu_pkg: shared fetcher state encoding and saturating counter helper
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MISS_WAIT = 2'b01,
        RELEASE   = 2'b10
    } fetch_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped valid/tag/data store with combinational lookup and single-port fill
module icache_array #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int NUM_LINES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] lookup_addr,
    output logic                 hit,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 fill_en,
    input  logic [ADDR_BITS-1:0] fill_addr,
    input  logic [DATA_BITS-1:0] fill_data,
    input  logic                 flush
);
    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
    logic [DATA_BITS-1:0] r_data [NUM_LINES];

    logic [IDX_BITS-1:0] w_lk_idx, w_fill_idx;
    logic [TAG_BITS-1:0] w_lk_tag, w_fill_tag;

    assign w_lk_idx   = lookup_addr[IDX_BITS-1:0];
    assign w_lk_tag   = lookup_addr[ADDR_BITS-1:IDX_BITS];
    assign w_fill_idx = fill_addr[IDX_BITS-1:0];
    assign w_fill_tag = fill_addr[ADDR_BITS-1:IDX_BITS];
    assign hit        = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign rd_data    = r_data[w_lk_idx];

    // Valid bits: flush wipes every line, otherwise a fill marks its line valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_valid <= '0;
        else if (flush)
            r_valid <= '0;
        else if (fill_en)
            r_valid[w_fill_idx] <= 1'b1;
    end

    // Tag and data payload need no reset; they are meaningless while the line is invalid
    always_ff @(posedge clk) begin
        if (fill_en) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/fetcher_icache.sv
// fetcher_icache: instruction fetch stage serving hits from a direct-mapped cache and misses from program memory
module fetcher_icache
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int NUM_LINES             = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             fetch_req,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] fetch_pc,
    output logic                             fetch_done,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);
    fetch_state_t                     r_state, w_state;
    logic                             r_done, w_done;
    logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr, w_instr;
    logic                             r_mrv, w_mrv;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] r_addr, w_addr;
    logic [15:0]                      r_hits, w_hits;
    logic [15:0]                      r_misses, w_misses;
    logic                             r_flushed, w_flushed;
    logic                             w_fill;
    logic                             w_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] w_rd_data;

    icache_array #(
        .ADDR_BITS(PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS(PROGRAM_MEM_DATA_BITS),
        .NUM_LINES(NUM_LINES)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .lookup_addr(fetch_pc),
        .hit        (w_hit),
        .rd_data    (w_rd_data),
        .fill_en    (w_fill),
        .fill_addr  (r_addr),
        .fill_data  (mem_read_data),
        .flush      (flush)
    );

    assign fetch_done       = r_done;
    assign instruction      = r_instr;
    assign mem_read_valid   = r_mrv;
    assign mem_read_address = r_addr;
    assign hit_count        = r_hits;
    assign miss_count       = r_misses;

    // State and registered outputs; reset drops an outstanding read request immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_done    <= 1'b0;
            r_instr   <= '0;
            r_mrv     <= 1'b0;
            r_addr    <= '0;
            r_hits    <= '0;
            r_misses  <= '0;
            r_flushed <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_done    <= w_done;
            r_instr   <= w_instr;
            r_mrv     <= w_mrv;
            r_addr    <= w_addr;
            r_hits    <= w_hits;
            r_misses  <= w_misses;
            r_flushed <= w_flushed;
        end
    end

    // Next-state logic: lookup in IDLE, wait for memory in MISS_WAIT, hold off new requests in RELEASE
    always_comb begin
        w_state   = r_state;
        w_done    = 1'b0;
        w_instr   = r_instr;
        w_mrv     = r_mrv;
        w_addr    = r_addr;
        w_hits    = r_hits;
        w_misses  = r_misses;
        w_flushed = r_flushed;
        w_fill    = 1'b0;
        case (r_state)
            IDLE: begin
                if (fetch_req && !flush) begin
                    if (w_hit) begin
                        w_instr = w_rd_data;
                        w_done  = 1'b1;
                        w_hits  = sat_inc(r_hits);
                        w_state = RELEASE;
                    end else begin
                        w_mrv     = 1'b1;
                        w_addr    = fetch_pc;
                        w_misses  = sat_inc(r_misses);
                        w_flushed = 1'b0;
                        w_state   = MISS_WAIT;
                    end
                end
            end
            MISS_WAIT: begin
                if (flush)
                    w_flushed = 1'b1;
                if (mem_read_ready) begin
                    w_mrv   = 1'b0;
                    w_instr = mem_read_data;
                    w_done  = 1'b1;
                    w_fill  = !flush && !r_flushed;
                    w_state = RELEASE;
                end
            end
            RELEASE: begin
                if (!fetch_req && !mem_read_ready)
                    w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetcher_icache.sv
// tb_fetcher_icache: directed self-checking bench for the cached instruction fetcher
module tb_fetcher_icache;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [7:0]  fetch_pc = '0;
    logic        fetch_done;
    logic [15:0] instruction;
    logic        flush = 1'b0;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready = 1'b0;
    logic [15:0] mem_read_data = '0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    int          n_checks = 0;
    int          n_fails = 0;

    fetcher_icache dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .fetch_pc        (fetch_pc),
        .fetch_done      (fetch_done),
        .instruction     (instruction),
        .flush           (flush),
        .mem_read_valid  (mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_miss(input logic [7:0] pc, input logic [15:0] data, input int delay, input logic [15:0] exp_misses);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        tick;
        chk("miss_valid", mem_read_valid, 1'b1);
        chk("miss_addr", mem_read_address, pc);
        chk("miss_count", miss_count, exp_misses);
        for (int d = 1; d < delay; d++) begin
            tick;
            chk("miss_hold_valid", mem_read_valid, 1'b1);
            chk("miss_done_low", fetch_done, 1'b0);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        tick;
        chk("miss_done", fetch_done, 1'b1);
        chk("miss_instr", instruction, data);
        chk("miss_valid_drop", mem_read_valid, 1'b0);
        mem_read_ready = 1'b0;
        fetch_req      = 1'b0;
        tick;
        chk("miss_pulse_end", fetch_done, 1'b0);
        chk("miss_instr_held", instruction, data);
    endtask

    task automatic do_hit(input logic [7:0] pc, input logic [15:0] data, input logic [15:0] exp_hits);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        tick;
        chk("hit_done", fetch_done, 1'b1);
        chk("hit_instr", instruction, data);
        chk("hit_no_mem", mem_read_valid, 1'b0);
        chk("hit_count", hit_count, exp_hits);
        fetch_req = 1'b0;
        tick;
        chk("hit_pulse_end", fetch_done, 1'b0);
    endtask

    initial begin
        #3;
        chk("rst_done", fetch_done, 1'b0);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_valid", mem_read_valid, 1'b0);
        chk("rst_addr", mem_read_address, 8'h00);
        chk("rst_hits", hit_count, 16'h0000);
        chk("rst_misses", miss_count, 16'h0000);
        #4 reset = 1'b0;
        tick;
        do_miss(8'h05, 16'hA1B2, 3, 16'd1);
        chk("cold_hits", hit_count, 16'd0);
        do_hit(8'h05, 16'hA1B2, 16'd1);
        do_miss(8'h03, 16'h1111, 1, 16'd2);
        do_miss(8'h0B, 16'h2222, 2, 16'd3);
        do_miss(8'h03, 16'h1111, 1, 16'd4);
        do_hit(8'h03, 16'h1111, 16'd2);
        fetch_req = 1'b1;
        fetch_pc  = 8'h07;
        tick;
        chk("fl_valid", mem_read_valid, 1'b1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("fl_valid_kept", mem_read_valid, 1'b1);
        chk("fl_addr_kept", mem_read_address, 8'h07);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h7777;
        tick;
        chk("fl_done", fetch_done, 1'b1);
        chk("fl_instr", instruction, 16'h7777);
        mem_read_ready = 1'b0;
        fetch_req      = 1'b0;
        tick;
        do_miss(8'h07, 16'h7777, 1, 16'd6);
        do_hit(8'h07, 16'h7777, 16'd3);
        do_miss(8'h05, 16'hA1B2, 1, 16'd7);
        fetch_req = 1'b1;
        fetch_pc  = 8'h10;
        tick;
        chk("sr_valid", mem_read_valid, 1'b1);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h5555;
        tick;
        chk("sr_done", fetch_done, 1'b1);
        chk("sr_instr", instruction, 16'h5555);
        fetch_req = 1'b0;
        tick;
        chk("sr_hold1", mem_read_valid, 1'b0);
        fetch_req = 1'b1;
        fetch_pc  = 8'h21;
        tick;
        chk("sr_hold2", mem_read_valid, 1'b0);
        fetch_req = 1'b0;
        tick;
        chk("sr_hold3", mem_read_valid, 1'b0);
        mem_read_ready = 1'b0;
        tick;
        chk("sr_idle", mem_read_valid, 1'b0);
        chk("sr_misses", miss_count, 16'd8);
        do_miss(8'h21, 16'h6666, 2, 16'd9);
        do_hit(8'h21, 16'h6666, 16'd4);
        fetch_req = 1'b1;
        fetch_pc  = 8'h30;
        tick;
        chk("ar_valid", mem_read_valid, 1'b1);
        chk("ar_misses_pre", miss_count, 16'd10);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid_drop", mem_read_valid, 1'b0);
        chk("ar_hits", hit_count, 16'd0);
        chk("ar_misses", miss_count, 16'd0);
        chk("ar_addr", mem_read_address, 8'h00);
        chk("ar_instr", instruction, 16'h0000);
        reset     = 1'b0;
        fetch_req = 1'b0;
        tick;
        chk("ar_idle", mem_read_valid, 1'b0);
        do_miss(8'h21, 16'h6666, 1, 16'd1);
        chk("ar_hits_after", hit_count, 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
